// File: rtl/dbus_sram_ctrl.sv
// dbus_sram_ctrl: bridges a stalling CPU data bus to an asynchronous SRAM.
// Each request runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE. The CPU is
// stalled from the request cycle through the last ACCESS cycle.
module dbus_sram_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dbus_address,
    input  logic [3:0]  dbus_byteenable,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [31:0] dbus_wrdata,
    output logic [31:0] dbus_rddata,
    output logic        dbus_stall,
    output logic [19:0] sram_addr,
    output logic [31:0] sram_data_o,
    input  logic [31:0] sram_data_i,
    output logic        sram_data_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [3:0]  sram_be_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [19:0] addr_q, addr_d;
    logic [3:0]  be_n_q, be_n_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rddata_q, rddata_d;

    logic req;
    assign req = dbus_read | dbus_write;

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            addr_q   <= 20'd0;
            be_n_q   <= 4'hF;
            wdata_q  <= 32'd0;
            rddata_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            be_n_q   <= be_n_d;
            wdata_q  <= wdata_d;
            rddata_q <= rddata_d;
        end
    end

    // Next state, request latching, access countdown and read capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        be_n_d   = be_n_q;
        wdata_d  = wdata_q;
        rddata_d = rddata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_LD;
                    // A simultaneous read+write is treated as a write.
                    wr_d    = dbus_write;
                    addr_d  = dbus_address[21:2];
                    be_n_d  = ~dbus_byteenable;
                    wdata_d = dbus_wrdata;
                end
            end
            ACCESS: begin
                // Counter saturates at zero; it is reloaded on every request.
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                    if (!wr_q) rddata_d = sram_data_i;
                end
            end
            DONE: begin
                // Requests are not sampled here; the CPU is advancing.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes and stall decoded from the current state and latched op.
    always_comb begin
        dbus_stall   = 1'b0;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_data_oe = 1'b0;
        case (state_q)
            IDLE: begin
                dbus_stall = req & ~rst;
            end
            ACCESS: begin
                dbus_stall   = 1'b1;
                sram_ce_n    = 1'b0;
                sram_oe_n    = wr_q;
                sram_we_n    = ~wr_q;
                sram_data_oe = wr_q;
            end
            DONE: begin
                // Keep driving write data one extra cycle for SRAM hold time.
                sram_data_oe = wr_q;
            end
            default: ;
        endcase
    end

    assign sram_addr   = addr_q;
    assign sram_be_n   = be_n_q;
    assign sram_data_o = wdata_q;
    assign dbus_rddata = rddata_q;

endmodule

// File: tb/tb_dbus_sram_ctrl.sv
// Directed bench for dbus_sram_ctrl: WAIT_CYCLES=2 main instance plus a
// WAIT_CYCLES=1 instance for the short-access case.
`timescale 1ns/1ps
module tb_dbus_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dbus_address;
    logic [3:0]  dbus_byteenable;
    logic        dbus_read, dbus_write;
    logic [31:0] dbus_wrdata;
    logic [31:0] dbus_rddata;
    logic        dbus_stall;
    logic [19:0] sram_addr;
    logic [31:0] sram_data_o, sram_data_i;
    logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    // Second instance (WAIT_CYCLES=1) with its own request signals.
    logic [31:0] a1, rd1, di1, do1;
    logic        r1, st1, oe1, ce1, oen1, wen1;
    logic [19:0] sa1;
    logic [3:0]  ben1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dbus_sram_ctrl #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .dbus_address(dbus_address), .dbus_byteenable(dbus_byteenable),
        .dbus_read(dbus_read), .dbus_write(dbus_write),
        .dbus_wrdata(dbus_wrdata), .dbus_rddata(dbus_rddata),
        .dbus_stall(dbus_stall), .sram_addr(sram_addr),
        .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
        .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    dbus_sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .dbus_address(a1), .dbus_byteenable(4'hF),
        .dbus_read(r1), .dbus_write(1'b0),
        .dbus_wrdata(32'h0), .dbus_rddata(rd1),
        .dbus_stall(st1), .sram_addr(sa1),
        .sram_data_o(do1), .sram_data_i(di1),
        .sram_data_oe(oe1), .sram_ce_n(ce1),
        .sram_oe_n(oen1), .sram_we_n(wen1), .sram_be_n(ben1)
    );

    // {stall, ce_n, oe_n, we_n, data_oe}
    logic [4:0] ctl;
    assign ctl = {dbus_stall, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; dbus_read = 1'b1; dbus_write = 1'b0;
        dbus_address = 32'h0000_0104; dbus_byteenable = 4'hF;
        dbus_wrdata = 32'h0; sram_data_i = 32'h0;
        r1 = 1'b0; a1 = 32'h0; di1 = 32'h0;
        step; step;
        checks++;
        if (ctl !== 5'b01110) begin
            errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b01110);
        end
        checks++;
        if ({dbus_rddata, sram_addr, sram_data_o, sram_be_n} !== {32'h0, 20'h0, 32'h0, 4'hF}) begin
            errors++;
            $display("FAIL reset_regs got rd=%h a=%h do=%h be=%b exp 0/0/0/1111",
                     dbus_rddata, sram_addr, sram_data_o, sram_be_n);
        end
        dbus_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step;
        checks++;
        if (ctl !== 5'b01110) begin
            errors++; $display("FAIL idle_ctl got=%b exp=%b", ctl, 5'b01110);
        end
    endtask

    task automatic test_read;
        dbus_read = 1'b1; dbus_address = 32'h0000_0104; dbus_byteenable = 4'hF;
        sram_data_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (ctl !== 5'b11110) begin
            errors++; $display("FAIL rd_req_ctl got=%b exp=%b", ctl, 5'b11110);
        end
        for (int i = 0; i < 2; i++) begin
            step;
            checks++;
            if (ctl !== 5'b10010 || sram_addr !== 20'h00041 || sram_be_n !== 4'h0) begin
                errors++;
                $display("FAIL rd_access%0d got ctl=%b a=%h be=%b exp 10010/00041/0000",
                         i, ctl, sram_addr, sram_be_n);
            end
        end
        step;
        checks++;
        if (ctl !== 5'b01110 || dbus_rddata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_done got ctl=%b rd=%h exp 01110/deadbeef", ctl, dbus_rddata);
        end
        dbus_read = 1'b0;
    endtask

    task automatic test_write;
        step;
        dbus_write = 1'b1; dbus_address = 32'h0000_0008; dbus_byteenable = 4'b0011;
        dbus_wrdata = 32'h1234_5678; sram_data_i = 32'h0F0F_0F0F;
        #1;
        checks++;
        if (ctl !== 5'b11110) begin
            errors++; $display("FAIL wr_req_ctl got=%b exp=%b", ctl, 5'b11110);
        end
        for (int i = 0; i < 2; i++) begin
            step;
            checks++;
            if (ctl !== 5'b10101 || sram_addr !== 20'h00002 || sram_be_n !== 4'b1100 ||
                sram_data_o !== 32'h1234_5678) begin
                errors++;
                $display("FAIL wr_access%0d got ctl=%b a=%h be=%b do=%h exp 10101/00002/1100/12345678",
                         i, ctl, sram_addr, sram_be_n, sram_data_o);
            end
        end
        step;
        checks++;
        if (ctl !== 5'b01111 || dbus_rddata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_done got ctl=%b rd=%h exp 01111/deadbeef", ctl, dbus_rddata);
        end
        dbus_write = 1'b0;
        step;
        checks++;
        if (ctl !== 5'b01110 || sram_addr !== 20'h00002 || sram_be_n !== 4'b1100 ||
            dbus_rddata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_idle_hold got ctl=%b a=%h be=%b rd=%h exp 01110/00002/1100/deadbeef",
                     ctl, sram_addr, sram_be_n, dbus_rddata);
        end
    endtask

    task automatic test_rd_wr_both;
        int oe_low = 0;
        int we_low = 0;
        dbus_read = 1'b1; dbus_write = 1'b1; dbus_address = 32'h0000_0010;
        dbus_byteenable = 4'hF; dbus_wrdata = 32'hCAFE_F00D;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n) we_low++;
            if (i < 3) step;
        end
        checks++;
        if (oe_low !== 0 || we_low !== 2 || sram_addr !== 20'h00004 ||
            dbus_rddata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL both_is_write got oe_low=%0d we_low=%0d a=%h rd=%h exp 0/2/00004/deadbeef",
                     oe_low, we_low, sram_addr, dbus_rddata);
        end
        dbus_read = 1'b0; dbus_write = 1'b0;
    endtask

    task automatic test_back_to_back;
        int cyc = 1;
        step;
        dbus_write = 1'b1; dbus_address = 32'h0; dbus_wrdata = 32'h0000_00AA;
        #1;
        while (dbus_stall && cyc < 10) begin step; cyc++; end
        // cyc is now the DONE cycle of the write (cycle 4).
        checks++;
        if (cyc !== 4 || ctl !== 5'b01111) begin
            errors++; $display("FAIL b2b_first got cyc=%0d ctl=%b exp 4/01111", cyc, ctl);
        end
        dbus_write = 1'b0; dbus_read = 1'b1; dbus_address = 32'h0000_0004;
        sram_data_i = 32'h0BAD_F00D;
        step; cyc++;
        checks++;
        if (ctl !== 5'b11110) begin
            errors++; $display("FAIL b2b_second_stall got ctl=%b exp 11110", ctl);
        end
        while (dbus_stall && cyc < 20) begin step; cyc++; end
        checks++;
        if (cyc !== 8 || dbus_rddata !== 32'h0BAD_F00D || sram_addr !== 20'h00001) begin
            errors++;
            $display("FAIL b2b_total got cyc=%0d rd=%h a=%h exp 8/0badf00d/00001",
                     cyc, dbus_rddata, sram_addr);
        end
        dbus_read = 1'b0;
    endtask

    task automatic test_reset_mid_access;
        int cyc = 0;
        step;
        dbus_read = 1'b1; dbus_address = 32'h0000_0020; sram_data_i = 32'h1111_2222;
        step; step;                    // now in second ACCESS cycle
        checks++;
        if (ctl !== 5'b10010) begin
            errors++; $display("FAIL rstmid_pre got ctl=%b exp 10010", ctl);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b01110 || dbus_rddata !== 32'h0 || sram_addr !== 20'h0 ||
            sram_be_n !== 4'hF) begin
            errors++;
            $display("FAIL rstmid_abort got ctl=%b rd=%h a=%h be=%b exp 01110/0/0/1111",
                     ctl, dbus_rddata, sram_addr, sram_be_n);
        end
        #2;
        rst = 1'b0;
        #1;
        cyc = 1;
        checks++;
        if (ctl !== 5'b11110) begin
            errors++; $display("FAIL rstmid_restart got ctl=%b exp 11110", ctl);
        end
        while (dbus_stall && cyc < 10) begin step; cyc++; end
        checks++;
        if (cyc !== 4 || dbus_rddata !== 32'h1111_2222 || sram_addr !== 20'h00008) begin
            errors++;
            $display("FAIL rstmid_complete got cyc=%0d rd=%h a=%h exp 4/11112222/00008",
                     cyc, dbus_rddata, sram_addr);
        end
        dbus_read = 1'b0;
    endtask

    task automatic test_zero_be;
        step;
        dbus_read = 1'b1; dbus_address = 32'hFFC0_000B; dbus_byteenable = 4'h0;
        sram_data_i = 32'h55AA_55AA;
        step;
        checks++;
        if (ctl !== 5'b10010 || sram_be_n !== 4'hF || sram_addr !== 20'h00002) begin
            errors++;
            $display("FAIL zero_be_access got ctl=%b be=%b a=%h exp 10010/1111/00002",
                     ctl, sram_be_n, sram_addr);
        end
        step; step;
        checks++;
        if (ctl !== 5'b01110 || dbus_rddata !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL zero_be_done got ctl=%b rd=%h exp 01110/55aa55aa", ctl, dbus_rddata);
        end
        dbus_read = 1'b0;
    endtask

    task automatic test_wait1;
        int cyc = 1;
        int stall_cnt = 0;
        step;
        r1 = 1'b1; a1 = 32'h0; di1 = 32'hA5A5_A5A5;
        #1;
        while (st1 && cyc < 10) begin stall_cnt++; step; cyc++; end
        checks++;
        if (stall_cnt !== 2 || rd1 !== 32'hA5A5_A5A5 || ce1 !== 1'b1) begin
            errors++;
            $display("FAIL wait1_read got stall=%0d rd=%h ce_n=%b exp 2/a5a5a5a5/1",
                     stall_cnt, rd1, ce1);
        end
        r1 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_rd_wr_both;
        test_back_to_back;
        test_reset_mid_access;
        test_zero_be;
        test_wait1;
        step;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
